snitch_sb_tag_ctrl: RTL and testbench

Scoreboard tag controller for the Snitch integer scoreboard. It owns the free-tag pool and shares it between `NumReq` issue requesters through a round-robin arbiter, at most one tag allocated per cycle. It tracks which tags are in flight, returns retired tags to the pool, and runs a multi-cycle flush sequence that reclaims every outstanding tag. It sits between the issue stage(s) and the writeback/retire logic.

---
 rtl/snitch_sb_pkg.sv | 16 +
 rtl/snitch_sb_ipool.sv | 51 +++++
 rtl/snitch_sb_tag_ctrl.sv | 165 ++++++++++++++++
 tb/tb_snitch_sb_tag_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_sb_pkg.sv
// Shared types for the Snitch scoreboard tag controller.
//   tag_t           : scoreboard tag at the default configuration (8 tags)
//   sb_ctrl_state_e : controller FSM state (normal operation / flush scan)
package snitch_sb_pkg;

    localparam int unsigned DefaultNumTags = 8;
    localparam int unsigned DefaultTagW    = $clog2(DefaultNumTags);

    typedef logic [DefaultTagW-1:0] tag_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } sb_ctrl_state_e;

endpackage

// File: rtl/snitch_sb_ipool.sv
// Free-tag pool: a circular FIFO that comes out of reset full, holding the
// values 0..Depth-1 in ascending order with the head at entry 0.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : append push_data_i at the tail
//   pop_i         : drop the head entry (pop_data_o is the current head)
//   empty_o/full_o: occupancy flags from the pool's own usage count
module snitch_sb_ipool
    import snitch_sb_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned W     = $clog2(Depth)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [Depth];
    logic [W-1:0] head_q, tail_q;
    logic [W:0]   cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= W'(i);
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= (W+1)'(Depth);
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= tail_q + W'(1);
            end
            if (pop_i) begin
                head_q <= head_q + W'(1);
            end
            cnt_q <= cnt_q + (W+1)'(push_i) - (W+1)'(pop_i);
        end
    end

    assign pop_data_o = mem_q[head_q];
    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == (W+1)'(Depth));

endmodule

// File: rtl/snitch_sb_tag_ctrl.sv
// Scoreboard tag controller: hands out free tags to NumReq requesters via a
// round-robin arbiter (one grant per cycle), tracks in-flight tags, takes
// retired tags back and runs a NumTags-cycle flush scan reclaiming all tags.
//   req_valid_i/req_ready_o/req_tag_o : allocation handshake, one-hot grant
//   retire_valid_i/retire_tag_i       : tag return
//   flush_i/flush_busy_o              : flush request / scan in progress
//   free_cnt_o, inflight_o            : pool occupancy and in-flight mask
//   err_double_free_o                 : pulse after a retire of a free tag
module snitch_sb_tag_ctrl
    import snitch_sb_pkg::*;
#(
    parameter int unsigned NumTags = 8,
    parameter int unsigned NumReq  = 2,
    parameter int unsigned TagW    = $clog2(NumTags)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumReq-1:0]  req_valid_i,
    output logic [NumReq-1:0]  req_ready_o,
    output logic [TagW-1:0]    req_tag_o,
    input  logic               retire_valid_i,
    input  logic [TagW-1:0]    retire_tag_i,
    input  logic               flush_i,
    output logic               flush_busy_o,
    output logic [TagW:0]      free_cnt_o,
    output logic [NumTags-1:0] inflight_o,
    output logic               err_double_free_o
);

    localparam int unsigned RrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    sb_ctrl_state_e     state_q, state_d;
    logic [TagW-1:0]    idx_q, idx_d;
    logic [RrW-1:0]     rr_q, rr_d;
    logic [NumTags-1:0] inflight_q, inflight_d;
    logic [TagW:0]      free_cnt_q, free_cnt_d;
    logic               err_q, err_d;

    logic               pool_push, pool_pop, pool_empty, pool_full;
    logic [TagW-1:0]    pool_push_tag, pool_head;

    logic [NumReq-1:0]  gnt;
    logic               gnt_found;
    logic [RrW-1:0]     gnt_idx;
    logic [RrW-1:0]     cand;
    logic               grant_en;

    snitch_sb_ipool #(
        .Depth (NumTags),
        .W     (TagW)
    ) i_pool (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (pool_push),
        .push_data_i (pool_push_tag),
        .pop_i       (pool_pop),
        .pop_data_o  (pool_head),
        .empty_o     (pool_empty),
        .full_o      (pool_full)
    );

    // Rotate-priority search starting at the round-robin pointer.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            cand = RrW'((32'(rr_q) + off) % NumReq);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt[cand] = 1'b1;
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant only depends on registered pool state, never on retire_*, so a
    // retired tag becomes grantable one cycle later at the earliest.
    assign grant_en  = (state_q == IDLE) && !flush_i && !pool_empty;
    assign req_tag_o = pool_head;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rr_d          = rr_q;
        inflight_d    = inflight_q;
        err_d         = 1'b0;
        pool_push     = 1'b0;
        pool_push_tag = retire_tag_i;
        pool_pop      = 1'b0;
        req_ready_o   = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_en) begin
                    req_ready_o = gnt;
                    if (gnt_found) begin
                        pool_pop              = 1'b1;
                        inflight_d[pool_head] = 1'b1;
                        rr_d = RrW'((32'(gnt_idx) + 1) % NumReq);
                    end
                end
                // Legality uses the in-flight mask at cycle start, so retiring
                // the tag being granted this very cycle counts as a double free.
                if (retire_valid_i) begin
                    if (inflight_q[retire_tag_i]) begin
                        pool_push                = 1'b1;
                        inflight_d[retire_tag_i] = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (flush_i) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                end
            end
            FLUSH: begin
                if (inflight_q[idx_q]) begin
                    pool_push         = 1'b1;
                    pool_push_tag     = idx_q;
                    inflight_d[idx_q] = 1'b0;
                end
                idx_d = idx_q + TagW'(1);
                if (idx_q == TagW'(NumTags - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        free_cnt_d = free_cnt_q + (TagW+1)'(pool_push) - (TagW+1)'(pool_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rr_q       <= '0;
            inflight_q <= '0;
            free_cnt_q <= (TagW+1)'(NumTags);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign flush_busy_o      = (state_q == FLUSH);
    assign free_cnt_o        = free_cnt_q;
    assign inflight_o        = inflight_q;
    assign err_double_free_o = err_q;

    // A tag can only be legally returned while it is in flight, so the pool
    // cannot be full at that moment.
    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(pool_push && pool_full && !pool_pop)
    );

endmodule

// File: tb/tb_snitch_sb_tag_ctrl.sv
module tb_snitch_sb_tag_ctrl;

    localparam int NT = 8;
    localparam int NR = 2;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [TW-1:0] req_tag;
    logic          retire_valid = 1'b0;
    logic [TW-1:0] retire_tag = '0;
    logic          flush = 1'b0;
    logic          flush_busy;
    logic [TW:0]   free_cnt;
    logic [NT-1:0] inflight;
    logic          err_df;

    always #5 clk = ~clk;

    snitch_sb_tag_ctrl #(
        .NumTags (NT),
        .NumReq  (NR)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_tag_o         (req_tag),
        .retire_valid_i    (retire_valid),
        .retire_tag_i      (retire_tag),
        .flush_i           (flush),
        .flush_busy_o      (flush_busy),
        .free_cnt_o        (free_cnt),
        .inflight_o        (inflight),
        .err_double_free_o (err_df)
    );

    typedef struct { int req; int tag; } gnt_t;
    typedef struct { int free; logic [NT-1:0] infl; bit busy; bit err; } st_t;

    gnt_t gq[$];
    st_t  sq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   started = 1'b0;

    // Reference model: free list as a queue, in-flight set as a bit array.
    int pool[$];
    bit infl[NT];
    int rr;
    int flush_left;
    int fidx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic st_t snapshot(input bit err);
        st_t s;
        s.free = pool.size();
        for (int i = 0; i < NT; i++) s.infl[i] = infl[i];
        s.busy = (flush_left > 0);
        s.err  = err;
        return s;
    endfunction

    task automatic model_reset();
        pool.delete();
        for (int i = 0; i < NT; i++) begin
            pool.push_back(i);
            infl[i] = 1'b0;
        end
        rr = 0;
        flush_left = 0;
        fidx = 0;
    endtask

    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_ni = 1'b0;
            req_valid = '0;
            retire_valid = 1'b0;
            flush = 1'b0;
            model_reset();
            sq.push_back(snapshot(1'b0));
            started = 1'b1;
        end
    endtask

    task automatic step(input logic [NR-1:0] v, input bit rv, input int rt, input bit fl);
        bit busy0, legal, err;
        int g, t;
        @(negedge clk);
        rst_ni = 1'b1;
        req_valid = v;
        retire_valid = rv;
        retire_tag = TW'(rt);
        flush = fl;
        busy0 = (flush_left > 0);
        legal = infl[rt];
        err = 1'b0;
        g = -1;
        if (!busy0 && !fl && pool.size() > 0) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && v[(rr + k) % NR]) g = (rr + k) % NR;
            end
        end
        if (g >= 0) begin
            t = pool.pop_front();
            gq.push_back('{g, t});
            infl[t] = 1'b1;
            rr = (g + 1) % NR;
        end
        if (!busy0) begin
            if (rv) begin
                if (legal) begin
                    pool.push_back(rt);
                    infl[rt] = 1'b0;
                end else begin
                    err = 1'b1;
                end
            end
            if (fl) begin
                flush_left = NT;
                fidx = 0;
            end
        end else begin
            if (infl[fidx]) begin
                pool.push_back(fidx);
                infl[fidx] = 1'b0;
            end
            fidx++;
            flush_left--;
        end
        sq.push_back(snapshot(err));
        started = 1'b1;
    endtask

    task automatic random_step();
        int cands[$];
        int rt;
        for (int i = 0; i < NT; i++) if (infl[i]) cands.push_back(i);
        if (cands.size() > 0 && $urandom_range(0, 4) != 0)
            rt = cands[$urandom_range(0, cands.size() - 1)];
        else
            rt = $urandom_range(0, NT - 1);
        step(NR'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, rt,
             $urandom_range(0, 39) == 0);
    endtask

    // Grant monitor: combinational handshake, sampled after inputs settle.
    initial forever begin
        @(negedge clk);
        #2;
        if (started) begin
            if (req_ready !== '0) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", 32'(req_ready), 32'h0);
                end else begin
                    gnt_t e;
                    logic [31:0] expv;
                    e = gq.pop_front();
                    expv = 32'(1) << e.req;
                    check("grant_ready", 32'(req_ready), expv);
                    check("grant_tag", 32'(req_tag), 32'(e.tag));
                end
            end else begin
                check("missing_grant", 32'(gq.size()), 32'h0);
                gq.delete();
            end
        end
    end

    // State monitor: registered outputs after each active edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (started) begin
            if (sq.size() == 0) begin
                check("state_queue_empty", 32'h1, 32'h0);
            end else begin
                st_t e;
                e = sq.pop_front();
                check("free_cnt", 32'(free_cnt), 32'(e.free));
                check("inflight", 32'(inflight), 32'(e.infl));
                check("flush_busy", 32'(flush_busy), 32'(e.busy));
                check("err_double_free", 32'(err_df), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset_cycles(2);

        // Alternating grants, then exhaust the pool and regrant a retired tag.
        repeat (4) step(2'b11, 0, 0, 0);
        repeat (5) step(2'b11, 0, 0, 0);
        step(2'b01, 1, 5, 0);
        step(2'b01, 0, 0, 0);

        // Legal retire followed by a double free of the same tag.
        step(2'b00, 1, 2, 0);
        step(2'b00, 1, 2, 0);
        step(2'b00, 0, 0, 0);

        // Allocate 0..4, retire 1, flush, then drain the pool in order.
        reset_cycles(1);
        repeat (5) step(2'b01, 0, 0, 0);
        step(2'b00, 1, 1, 0);
        step(2'b00, 0, 0, 1);
        repeat (9) step(2'b00, 0, 0, 0);
        repeat (8) step(2'b01, 0, 0, 0);

        // Requests, retire and flush held high across a whole flush scan.
        step(2'b00, 0, 0, 1);
        repeat (8) step(2'b11, 1, 3, 1);
        step(2'b00, 0, 0, 0);

        // Reset three cycles into a flush.
        repeat (3) step(2'b11, 0, 0, 0);
        step(2'b00, 0, 0, 1);
        repeat (3) step(2'b00, 0, 0, 0);
        reset_cycles(1);
        step(2'b11, 0, 0, 0);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) reset_cycles(1);
            else random_step();
        end

        @(negedge clk);
        req_valid = '0;
        retire_valid = 1'b0;
        flush = 1'b0;
        started = 1'b0;
        sq.delete();
        @(posedge clk);
        #2;
        check("grant_queue_drained", 32'(gq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
